// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer: walks the M/N/K block loops for a 4x4x4 MAC array.
// It issues paired A/B tile reads, forwards the returned tiles with their
// array controls, and writes back one C tile per (m,n) block.
// Optional feature macro: GEMM_SEQ_PERF_CNT_EN adds cycle_cnt_o, a count of
// busy cycles for the most recent job.
module gemm_tile_sequencer #(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32,
  parameter int meshRow      = 4,
  parameter int meshCol      = 4,
  parameter int tileSize     = 4,
  parameter int SizeWidth    = 8,
  parameter int AddrWidth    = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     start_i,
  input  logic [SizeWidth-1:0]                     m_blocks_i,
  input  logic [SizeWidth-1:0]                     n_blocks_i,
  input  logic [SizeWidth-1:0]                     k_blocks_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     a_req_o,
  output logic [AddrWidth-1:0]                     a_addr_o,
  input  logic [meshRow*tileSize*InDataWidth-1:0]  a_rdata_i,
  output logic                                     b_req_o,
  output logic [AddrWidth-1:0]                     b_addr_o,
  input  logic [meshCol*tileSize*InDataWidth-1:0]  b_rdata_i,
  output logic [meshRow*tileSize*InDataWidth-1:0]  a_o,
  output logic [meshCol*tileSize*InDataWidth-1:0]  b_o,
  output logic                                     a_valid_o,
  output logic                                     b_valid_o,
  output logic                                     init_save_o,
  output logic                                     acc_clr_o,
  input  logic [meshRow*meshCol*OutDataWidth-1:0]  c_i,
  output logic                                     c_wr_o,
  output logic [AddrWidth-1:0]                     c_addr_o,
`ifdef GEMM_SEQ_PERF_CNT_EN
  output logic [31:0]                              cycle_cnt_o,
`endif
  output logic [meshRow*meshCol*OutDataWidth-1:0]  c_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_r;
  logic [SizeWidth-1:0]  m_sz_r, n_sz_r, k_sz_r;
  logic [SizeWidth-1:0]  m_sz_s, n_sz_s, k_sz_s;
  logic [SizeWidth-1:0]  m_r, n_r, k_r;
  logic [SizeWidth-1:0]  m_nxt_s, n_nxt_s, k_nxt_s;
  logic [AddrWidth-1:0]  mk_r, nk_r, mn_r;
  logic [AddrWidth-1:0]  mk_nxt_s, nk_nxt_s, mn_nxt_s;
  logic                  k_last_s, n_last_s, m_last_s, job_last_s;
  logic                  zero_s, issue_s;
  logic                  drain_r;
  logic                  req_r, first0_r, last0_r;
  logic [AddrWidth-1:0]  a_addr_r, b_addr_r, caddr0_r;
  logic                  valid_r, init_r, last1_r;
  logic [AddrWidth-1:0]  caddr1_r, caddr_r;
  logic                  cwr_r, busy_r, done_r, acc_clr_r;

  // Sizes come straight from the inputs while idle so the first issue can
  // go out on the same edge that accepts start.
  always_comb begin
    if (state_r == S_IDLE) begin
      m_sz_s = m_blocks_i;
      n_sz_s = n_blocks_i;
      k_sz_s = k_blocks_i;
    end else begin
      m_sz_s = m_sz_r;
      n_sz_s = n_sz_r;
      k_sz_s = k_sz_r;
    end
  end

  assign zero_s     = (m_blocks_i == {SizeWidth{1'b0}}) || (n_blocks_i == {SizeWidth{1'b0}}) ||
                      (k_blocks_i == {SizeWidth{1'b0}});
  assign issue_s    = (state_r == S_RUN) || ((state_r == S_IDLE) && start_i && !zero_s);
  assign k_last_s   = (k_r == k_sz_s - SizeWidth'(1));
  assign n_last_s   = (n_r == n_sz_s - SizeWidth'(1));
  assign m_last_s   = (m_r == m_sz_s - SizeWidth'(1));
  assign job_last_s = k_last_s && n_last_s && m_last_s;

  // Loop counter advance; the m*K, n*K and m*N bases grow by addition only.
  always_comb begin
    k_nxt_s  = k_r + SizeWidth'(1);
    n_nxt_s  = n_r;
    m_nxt_s  = m_r;
    nk_nxt_s = nk_r;
    mk_nxt_s = mk_r;
    mn_nxt_s = mn_r;
    if (job_last_s) begin
      k_nxt_s  = {SizeWidth{1'b0}};
      n_nxt_s  = {SizeWidth{1'b0}};
      m_nxt_s  = {SizeWidth{1'b0}};
      nk_nxt_s = {AddrWidth{1'b0}};
      mk_nxt_s = {AddrWidth{1'b0}};
      mn_nxt_s = {AddrWidth{1'b0}};
    end else if (k_last_s) begin
      k_nxt_s = {SizeWidth{1'b0}};
      if (n_last_s) begin
        n_nxt_s  = {SizeWidth{1'b0}};
        nk_nxt_s = {AddrWidth{1'b0}};
        m_nxt_s  = m_r + SizeWidth'(1);
        mk_nxt_s = mk_r + AddrWidth'(k_sz_s);
        mn_nxt_s = mn_r + AddrWidth'(n_sz_s);
      end else begin
        n_nxt_s  = n_r + SizeWidth'(1);
        nk_nxt_s = nk_r + AddrWidth'(k_sz_s);
      end
    end else begin
      k_nxt_s = k_r + SizeWidth'(1);
    end
  end

  // Control FSM plus the issue stage (read requests and their addresses).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= S_IDLE;
      m_sz_r    <= {SizeWidth{1'b0}};
      n_sz_r    <= {SizeWidth{1'b0}};
      k_sz_r    <= {SizeWidth{1'b0}};
      m_r       <= {SizeWidth{1'b0}};
      n_r       <= {SizeWidth{1'b0}};
      k_r       <= {SizeWidth{1'b0}};
      mk_r      <= {AddrWidth{1'b0}};
      nk_r      <= {AddrWidth{1'b0}};
      mn_r      <= {AddrWidth{1'b0}};
      drain_r   <= 1'b0;
      req_r     <= 1'b0;
      first0_r  <= 1'b0;
      last0_r   <= 1'b0;
      a_addr_r  <= {AddrWidth{1'b0}};
      b_addr_r  <= {AddrWidth{1'b0}};
      caddr0_r  <= {AddrWidth{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      acc_clr_r <= 1'b0;
    end else begin
      req_r     <= issue_s;
      done_r    <= 1'b0;
      acc_clr_r <= 1'b0;
      if (issue_s) begin
        a_addr_r <= mk_r + AddrWidth'(k_r);
        b_addr_r <= nk_r + AddrWidth'(k_r);
        caddr0_r <= mn_r + AddrWidth'(n_r);
        first0_r <= (k_r == {SizeWidth{1'b0}});
        last0_r  <= k_last_s;
        k_r      <= k_nxt_s;
        n_r      <= n_nxt_s;
        m_r      <= m_nxt_s;
        nk_r     <= nk_nxt_s;
        mk_r     <= mk_nxt_s;
        mn_r     <= mn_nxt_s;
      end else begin
        k_r <= k_r;
      end
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            m_sz_r <= m_blocks_i;
            n_sz_r <= n_blocks_i;
            k_sz_r <= k_blocks_i;
            if (zero_s) begin
              state_r <= S_DONE;
            end else begin
              busy_r    <= 1'b1;
              acc_clr_r <= 1'b1;
              state_r   <= job_last_s ? S_DRAIN : S_RUN;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          if (job_last_s) begin
            state_r <= S_DRAIN;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_DRAIN: begin
          drain_r <= !drain_r;
          if (drain_r) begin
            state_r <= S_DONE;
          end else begin
            state_r <= S_DRAIN;
          end
        end
        S_DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Stage 1 (tile presented to the array) and stage 2 (result write-back).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r  <= 1'b0;
      init_r   <= 1'b0;
      last1_r  <= 1'b0;
      caddr1_r <= {AddrWidth{1'b0}};
      cwr_r    <= 1'b0;
      caddr_r  <= {AddrWidth{1'b0}};
    end else begin
      valid_r  <= req_r;
      init_r   <= req_r && first0_r;
      last1_r  <= req_r && last0_r;
      caddr1_r <= caddr0_r;
      cwr_r    <= last1_r;
      if (last1_r) begin
        caddr_r <= caddr1_r;
      end else begin
        caddr_r <= caddr_r;
      end
    end
  end

`ifdef GEMM_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_r;

  // Busy-cycle counter: cleared by an accepted start, held after done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_r <= 32'd0;
    end else if ((state_r == S_IDLE) && start_i) begin
      cycle_cnt_r <= 32'd0;
    end else if (busy_r) begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  assign cycle_cnt_o = cycle_cnt_r;
`endif

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign a_req_o     = req_r;
  assign b_req_o     = req_r;
  assign a_addr_o    = a_addr_r;
  assign b_addr_o    = b_addr_r;
  assign a_o         = a_rdata_i;
  assign b_o         = b_rdata_i;
  assign a_valid_o   = valid_r;
  assign b_valid_o   = valid_r;
  assign init_save_o = init_r;
  assign acc_clr_o   = acc_clr_r;
  assign c_wr_o      = cwr_r;
  assign c_addr_o    = caddr_r;
  assign c_data_o    = c_i;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Bench for gemm_tile_sequencer: SRAM and MAC-array stand-ins, a per-cycle
// expectation table built from the loop-nest rules, and literal pins.
module tb_gemm_tile_sequencer;
  localparam int NC = 1024;

  logic         clk = 1'b0;
  logic         rst_i, start_i;
  logic [7:0]   m_blocks_i, n_blocks_i, k_blocks_i;
  logic         busy_o, done_o, a_req_o, b_req_o;
  logic [15:0]  a_addr_o, b_addr_o, c_addr_o;
  logic [127:0] a_rdata_i = '0, b_rdata_i = '0, a_o, b_o;
  logic         a_valid_o, b_valid_o, init_save_o, acc_clr_o, c_wr_o;
  logic [511:0] c_i, c_data_o;
  logic [31:0]  acc = 32'd0;
`ifdef GEMM_SEQ_PERF_CNT_EN
  logic [31:0]  cycle_cnt_o;
`endif

  gemm_tile_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .m_blocks_i(m_blocks_i), .n_blocks_i(n_blocks_i), .k_blocks_i(k_blocks_i),
    .busy_o(busy_o), .done_o(done_o),
    .a_req_o(a_req_o), .a_addr_o(a_addr_o), .a_rdata_i(a_rdata_i),
    .b_req_o(b_req_o), .b_addr_o(b_addr_o), .b_rdata_i(b_rdata_i),
    .a_o(a_o), .b_o(b_o), .a_valid_o(a_valid_o), .b_valid_o(b_valid_o),
    .init_save_o(init_save_o), .acc_clr_o(acc_clr_o),
    .c_i(c_i), .c_wr_o(c_wr_o), .c_addr_o(c_addr_o),
`ifdef GEMM_SEQ_PERF_CNT_EN
    .cycle_cnt_o(cycle_cnt_o),
`endif
    .c_data_o(c_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // expectation table, indexed by cycle
  bit        e_busy [NC], e_done [NC], e_req [NC], e_valid [NC];
  bit        e_init [NC], e_clr [NC], e_cwr [NC];
  bit [15:0] e_aaddr [NC], e_baddr [NC], e_caddr [NC];
  bit [31:0] e_cdata [NC];
  bit        obs_wr [NC], obs_done [NC];

  function automatic logic [7:0] afn(input logic [15:0] a);
    return 8'(a * 16'd3 + 16'd1);
  endfunction
  function automatic logic [7:0] bfn(input logic [15:0] a);
    return 8'(a * 16'd5 + 16'd2);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // operand SRAMs: tile data one cycle after the request
  always @(posedge clk) begin
    if (a_req_o) a_rdata_i <= {16{afn(a_addr_o)}};
    if (b_req_o) b_rdata_i <= {16{bfn(b_addr_o)}};
  end

  // abstract MAC array: accumulates element-0 products per block
  always @(posedge clk) begin
    if (a_valid_o && b_valid_o)
      acc <= (init_save_o ? 32'd0 : acc) + 32'(a_o[7:0]) * 32'(b_o[7:0]);
  end
  assign c_i = {16{acc}};

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Fill the table for a job started at cycle s; cycles >= abort are idle.
  task automatic plan_job(input int s, input int m, input int n, input int k, input int abort);
    int l, i, c;
    logic [31:0] sum;
    l = m * n * k;
    if (l == 0) begin
      e_done[s+2] = 1'b1;
      return;
    end
    e_clr[s+1] = 1'b1;
    for (c = s + 1; c <= s + l + 2; c++) e_busy[c] = 1'b1;
    e_done[s+l+3] = 1'b1;
    for (int mi = 0; mi < m; mi++)
      for (int ni = 0; ni < n; ni++) begin
        sum = 32'd0;
        for (int ki = 0; ki < k; ki++) begin
          i = (mi * n + ni) * k + ki;
          e_req[s+1+i]   = 1'b1;
          e_aaddr[s+1+i] = 16'(mi * k + ki);
          e_baddr[s+1+i] = 16'(ni * k + ki);
          e_valid[s+2+i] = 1'b1;
          e_init[s+2+i]  = (ki == 0);
          sum = sum + 32'(afn(16'(mi * k + ki))) * 32'(bfn(16'(ni * k + ki)));
          if (ki == k - 1) begin
            e_cwr[s+3+i]   = 1'b1;
            e_caddr[s+3+i] = 16'(mi * n + ni);
            e_cdata[s+3+i] = sum;
          end
        end
      end
    for (c = abort; c <= s + l + 4; c++) begin
      e_busy[c] = 0; e_done[c] = 0; e_req[c] = 0; e_valid[c] = 0;
      e_init[c] = 0; e_clr[c] = 0; e_cwr[c] = 0;
    end
  endtask

  // per-cycle compare against the table
  always @(negedge clk) begin
    if (chk_en && cyc < NC) begin
      obs_wr[cyc]   = c_wr_o;
      obs_done[cyc] = done_o;
      chk("busy", busy_o, e_busy[cyc]);
      chk("done", done_o, e_done[cyc]);
      chk("a_req", a_req_o, e_req[cyc]);
      chk("b_req", b_req_o, e_req[cyc]);
      chk("a_valid", a_valid_o, e_valid[cyc]);
      chk("b_valid", b_valid_o, e_valid[cyc]);
      chk("init_save", init_save_o, e_init[cyc]);
      chk("acc_clr", acc_clr_o, e_clr[cyc]);
      chk("c_wr", c_wr_o, e_cwr[cyc]);
      if (e_req[cyc]) begin
        chk("a_addr", a_addr_o, e_aaddr[cyc]);
        chk("b_addr", b_addr_o, e_baddr[cyc]);
      end
      if (e_cwr[cyc]) begin
        chk("c_addr", c_addr_o, e_caddr[cyc]);
        chk("c_data", c_data_o, {16{e_cdata[cyc]}});
      end
    end
  end

  // Start a job; optionally re-pulse start mid-run or assert reset at a cycle offset.
  task automatic run_job(input int m, input int n, input int k,
                         input int restart_at, input int rst_at, output int s);
    int l;
    l = m * n * k;
    @(negedge clk);
    s = cyc;
    plan_job(s, m, n, k, (rst_at > 0) ? s + rst_at + 1 : NC - 1);
    m_blocks_i = 8'(m); n_blocks_i = 8'(n); k_blocks_i = 8'(k);
    start_i = 1'b1;
    for (int t = 1; t < l + 7; t++) begin
      @(negedge clk);
      if (t == 1) start_i = 1'b0;
      if (t == restart_at) begin
        start_i = 1'b1;
        m_blocks_i = 8'd1; n_blocks_i = 8'd1; k_blocks_i = 8'd1;
      end
      if (restart_at > 0 && t == restart_at + 2) start_i = 1'b0;
      if (t == rst_at) rst_i = 1'b1;
      if (rst_at > 0 && t == rst_at + 1) begin
        rst_i = 1'b0;
        chk("rst_a_addr", a_addr_o, 16'd0);
        chk("rst_b_addr", b_addr_o, 16'd0);
        chk("rst_c_addr", c_addr_o, 16'd0);
        chk("rst_busy", busy_o, 1'b0);
      end
    end
  endtask

  int s, nw;

  initial begin
    rst_i = 1'b1; start_i = 1'b0;
    m_blocks_i = 8'd0; n_blocks_i = 8'd0; k_blocks_i = 8'd0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    chk_en = 1'b1;
    chk("reset_a_addr", a_addr_o, 16'd0);
    chk("reset_c_addr", c_addr_o, 16'd0);
    chk("reset_busy", busy_o, 1'b0);

    // M=1,N=4,K=16
    run_job(1, 4, 16, 0, 0, s);
    nw = 0;
    for (int c = s; c < s + 72; c++) nw += int'(obs_wr[c]);
    chk("t1_wr_count", 32'(nw), 32'd4);
    chk("t1_wr18", obs_wr[s+18], 1'b1);
    chk("t1_wr66", obs_wr[s+66], 1'b1);
    chk("t1_done67", obs_done[s+67], 1'b1);
    chk("t1_model_b_addr63", e_baddr[s+64], 16'd63);
    chk("t1_model_a_addr17", e_aaddr[s+18], 16'd1);
`ifdef GEMM_SEQ_PERF_CNT_EN
    chk("cycle_cnt", cycle_cnt_o, 32'd66);
`endif

    // M=2,N=2,K=1
    run_job(2, 2, 1, 0, 0, s);
    for (int c = 3; c <= 6; c++) chk("t2_wr_seq", obs_wr[s+c], 1'b1);
    chk("t2_done7", obs_done[s+7], 1'b1);
    chk("t2_model_caddr6", e_caddr[s+6], 16'd3);

    // K=0: nothing issued, done at cycle 2
    run_job(1, 1, 0, 0, 0, s);
    chk("t3_done2", obs_done[s+2], 1'b1);

    // start re-pulsed mid-run is ignored
    run_job(2, 3, 2, 4, 0, s);
    nw = 0;
    for (int c = s; c < s + 18; c++) nw += int'(obs_wr[c]);
    chk("t4_wr_count", 32'(nw), 32'd6);

    // reset at issue 10, then a clean rerun
    run_job(1, 2, 8, 0, 11, s);
    nw = 0;
    for (int c = s; c < s + 22; c++) nw += int'(obs_wr[c]);
    chk("t5_abort_wr_count", 32'(nw), 32'd1);
    run_job(1, 2, 8, 0, 0, s);
    chk("t5_rerun_done19", obs_done[s+19], 1'b1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
Upstream controller for the 4x4x4 MAC array. On a start pulse it walks the M, N and K block loops and issues A/B tile reads to the operand SRAMs. It forwards the returned tiles to the array together with valid, init_save and acc_clr controls. It captures each finished C tile from the array and emits one write per (m,n) block to the result buffer.

Parameters:
InDataWidth, 8, operand element width
OutDataWidth, 32, accumulator/result element width
meshRow, 4, array rows (A tile rows)
meshCol, 4, array columns (B tile rows)
tileSize, 4, K elements per tile
SizeWidth, 8, width of block-count inputs
AddrWidth, 16, SRAM/result address width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start pulse, sampled only in IDLE
m_blocks_i  in  SizeWidth  M_block count, latched on start
n_blocks_i  in  SizeWidth  N_block count, latched on start
k_blocks_i  in  SizeWidth  K_block count, latched on start
busy_o  out  1  high from first issue through last write
done_o  out  1  one-cycle pulse after last write
a_req_o  out  1  A SRAM read request
a_addr_o  out  AddrWidth  A tile address = m*K + k
a_rdata_i  in  meshRow*tileSize*InDataWidth  A tile data, arrives 1 cycle after request
b_req_o  out  1  B SRAM read request
b_addr_o  out  AddrWidth  B tile address = n*K + k
b_rdata_i  in  meshCol*tileSize*InDataWidth  B tile data, arrives 1 cycle after request
a_o  out  meshRow*tileSize*InDataWidth  to array a_i (= a_rdata_i)
b_o  out  meshCol*tileSize*InDataWidth  to array b_i (= b_rdata_i)
a_valid_o  out  1  to array a_valid_i
b_valid_o  out  1  to array b_valid_i
init_save_o  out  1  to array, high with the k=0 tile of each block
acc_clr_o  out  1  to array, one-cycle clear at job start
c_i  in  meshRow*meshCol*OutDataWidth  array c_o
c_wr_o  out  1  result write strobe
c_addr_o  out  AddrWidth  result address = m*N + n
c_data_o  out  meshRow*meshCol*OutDataWidth  result tile (= c_i)

Behaviour:
- Reset: all control outputs 0 (busy, done, req, valid, init_save, acc_clr, c_wr); addresses 0; FSM = IDLE; counters 0. Reset mid-job aborts immediately. No further reads or writes are issued.
- FSM states:
  - IDLE: on start_i, latch sizes. Any size = 0 -> DONE (no reads, no writes). Otherwise -> RUN.
  - RUN: one read pair per cycle. k is the inner loop, then n, then m. After issuing (M-1,N-1,K-1) -> DRAIN.
  - DRAIN: wait for the pipeline to empty (2 cycles) -> DONE.
  - DONE: done_o=1 for 1 cycle -> IDLE.
- start_i outside IDLE is ignored.
- Timing, with start sampled at cycle 0:
  - Issue i (0-based) occurs at cycle 1+i.
  - a_req_o and b_req_o are asserted together with their addresses.
- Stage 1 (cycle after issue):
  - a_valid_o and b_valid_o are registered copies of req.
  - init_save_o is a registered flag for k==0.
  - a_o and b_o pass through from SRAM data combinationally.
- Stage 2 (cycle after stage 1):
  - The array holds the result for a block whose last tile (k==K-1) was presented in stage 1.
  - c_wr_o=1, c_addr_o comes from the registered (m,n), and c_data_o=c_i.
- Back-to-back blocks need no bubble. The next block's init_save tile is captured by the array at the end of the write cycle, so c_i is still the previous result during that cycle.
- acc_clr_o=1 in cycle 1 only.
- busy_o is high in cycles 1 .. M*N*K+2.
- done_o fires at cycle M*N*K+3.
- Address arithmetic is unsigned, truncated to AddrWidth with no overflow detection. Products are computed incrementally with adders; no multipliers.
- K=1: every tile has init_save_o=1, and every stage-1 cycle is also a last tile, giving one write per issue cycle.

Optional Feature:
GEMM_SEQ_PERF_CNT_EN:
- With the macro defined, add output cycle_cnt_o (32 bits). It clears to 0 on an accepted start and increments every cycle busy_o is high. It holds its value after done until the next start, and resets to 0.
- Without the macro, the port and counter are absent.

Test Plan:
- M=1,N=4,K=16, start at cycle 0:
  - 64 consecutive read cycles; a_addr 0..15 repeated, b_addr 0..63.
  - Writes at cycles 18,34,50,66 with c_addr 0,1,2,3.
  - done at cycle 67.
  - Results match the golden A*B^T from an attached array model.
- M=2,N=2,K=1: init_save_o high on every valid cycle. 4 writes on consecutive cycles 3..6 with addrs 0,1,2,3; done at cycle 7.
- k_blocks_i=0: no req or c_wr, busy stays 0, done pulse at cycle 2.
- start_i reasserted during RUN: ignored; address sequence and write count unchanged.
- rst_i asserted at issue 10 of an M=1,N=2,K=8 job:
  - Next cycle all outputs 0 and FSM idle.
  - A fresh start then runs the full job correctly.
- With GEMM_SEQ_PERF_CNT_EN, M=1,N=4,K=16: cycle_cnt_o=66 after done.
